// File: rtl/sb_pkg.sv
// Store buffer shared defaults and the buffered-entry record.
package sb_pkg;
    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] address;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// Youngest-match search over the store buffer: scans from the head (oldest)
// towards the tail so the last matching slot found is the youngest.
module sb_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]        valid,
    input  logic [DEPTH*ADDR_W-1:0] addrs,
    input  logic [PTR_W-1:0]        rd_ptr,
    input  logic [ADDR_W-1:0]       query,
    output logic                    hit,
    output logic [PTR_W-1:0]        index
);
    logic [DEPTH-1:0] eq;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_eq
            assign eq[gi] = valid[gi] && (addrs[gi*ADDR_W +: ADDR_W] == query);
        end
    endgenerate

    always_comb begin
        logic [PTR_W-1:0] idx;
        hit   = 1'b0;
        index = rd_ptr;
        idx   = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (eq[idx]) begin
                hit   = 1'b1;
                index = idx;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the pipeline memory stage and data memory.
// Define STORE_FWD_EN to forward buffered store data to matching loads.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_write_data,
    output logic [DATA_W-1:0] cpu_read_data,
    output logic              cpu_stall,
    output logic              Mem_read,
    output logic              Mem_write,
    output logic [ADDR_W-1:0] Mem_address,
    output logic [DATA_W-1:0] Write_data,
    input  logic [DATA_W-1:0] Read_Data,
    output logic              sb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    sb_entry_t          entries_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [DEPTH-1:0]        valid_vec;
    logic [DEPTH*ADDR_W-1:0] addr_flat;
    logic               hit, full, load_stall, stall, accept, drain, mem_rd;
    logic [PTR_W-1:0]   hit_index;
    sb_entry_t          head;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign valid_vec[gi]                   = entries_reg[gi].valid;
            assign addr_flat[gi*ADDR_W +: ADDR_W]  = entries_reg[gi].address;

            always_ff @(posedge clk) begin
                if (reset) begin
                    entries_reg[gi].valid <= 1'b0;
                end else if (accept && wr_ptr_reg == PTR_W'(gi)) begin
                    entries_reg[gi] <= '{valid: 1'b1, address: cpu_address, data: cpu_write_data};
                end else if (drain && rd_ptr_reg == PTR_W'(gi)) begin
                    entries_reg[gi].valid <= 1'b0;
                end
            end
        end
    endgenerate

    sb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) u_match (
        .valid  (valid_vec),
        .addrs  (addr_flat),
        .rd_ptr (rd_ptr_reg),
        .query  (cpu_address),
        .hit    (hit),
        .index  (hit_index)
    );

    // Without forwarding, a load hit holds the pipeline while older stores drain.
    assign head       = entries_reg[rd_ptr_reg];
    assign full       = (count_reg == CNT_W'(DEPTH));
    assign load_stall = cpu_read && hit && !FWD;
    assign stall      = (cpu_write && full) || load_stall;
    assign accept     = cpu_write && !stall;
    assign drain      = (count_reg != '0) && ((!cpu_read && !cpu_write) || stall);
    assign mem_rd     = cpu_read && !hit;

    always_comb begin
        count_next = count_reg;
        if (accept)
            count_next = count_reg + 1'b1;
        else if (drain)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (accept)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (drain)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Outputs are forced quiet while reset is held, whatever state the flops hold.
    always_comb begin
        cpu_stall     = 1'b0;
        Mem_read      = 1'b0;
        Mem_write     = 1'b0;
        Mem_address   = '0;
        Write_data    = '0;
        cpu_read_data = '0;
        if (!reset) begin
            cpu_stall = stall;
            Mem_write = drain;
            Mem_read  = mem_rd;
            if (drain) begin
                Mem_address = head.address;
                Write_data  = head.data;
            end else if (mem_rd) begin
                Mem_address = cpu_address;
            end
            if (mem_rd)
                cpu_read_data = Read_Data;
            else if (cpu_read && hit && FWD)
                cpu_read_data = entries_reg[hit_index].data;
        end
    end

    assign sb_empty = reset || (count_reg == '0);
endmodule
